// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared opcode, funct and state definitions for the ula arbiter
package ula_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ula.sv
// rtl/ula.sv - combinational integer ALU for R-type and I-type operations
module ula
    import ula_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic [XLEN-1:0] result,
    output logic            err
);

    logic [4:0] shamt;
    logic       alt;
    logic       is_r;

    assign shamt = data2[4:0];
    assign alt   = (funct7 == F7_ALT);
    assign is_r  = (opcode == OP_R);

    // Decode funct3 into the operation; only the R-type ADD slot honours SUB,
    // while both shift-right forms honour the arithmetic variant.
    always_comb begin
        result = '0;
        err    = 1'b0;
        if (opcode == OP_R || opcode == OP_I) begin
            case (funct3)
                F3_ADD:  result = (is_r && alt) ? (data1 - data2) : (data1 + data2);
                F3_SLL:  result = data1 << shamt;
                F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(data2))};
                F3_SLTU: result = {{(XLEN-1){1'b0}}, (data1 < data2)};
                F3_XOR:  result = data1 ^ data2;
                F3_SR:   result = alt ? XLEN'($signed(data1) >>> shamt) : (data1 >> shamt);
                F3_OR:   result = data1 | data2;
                F3_AND:  result = data1 & data2;
            endcase
        end else begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/ula_arb.sv
// rtl/ula_arb.sv - round-robin arbiter sharing one ula between two requesters
module ula_arb
    import ula_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid_in,
    output logic            req0_ready_out,
    input  logic [XLEN-1:0] req0_data1_in,
    input  logic [XLEN-1:0] req0_data2_in,
    input  logic [6:0]      req0_opcode_in,
    input  logic [2:0]      req0_funct3_in,
    input  logic [6:0]      req0_funct7_in,
    input  logic            req1_valid_in,
    output logic            req1_ready_out,
    input  logic [XLEN-1:0] req1_data1_in,
    input  logic [XLEN-1:0] req1_data2_in,
    input  logic [6:0]      req1_opcode_in,
    input  logic [2:0]      req1_funct3_in,
    input  logic [6:0]      req1_funct7_in,
    output logic            rsp0_valid_out,
    input  logic            rsp0_ready_in,
    output logic [XLEN-1:0] rsp0_data_out,
    output logic            rsp0_err_out,
    output logic            rsp1_valid_out,
    input  logic            rsp1_ready_in,
    output logic [XLEN-1:0] rsp1_data_out,
    output logic            rsp1_err_out
);

    state_t          state;
    state_t          state_next;
    logic            grant;
    logic            gid;
    logic            last_grant;
    logic            in_idle;
    logic            in_resp;
    logic            xfer;
    logic            rsp_ready_g;

    logic [XLEN-1:0] op_data1;
    logic [XLEN-1:0] op_data2;
    logic [6:0]      op_opcode;
    logic [2:0]      op_funct3;
    logic [6:0]      op_funct7;
    logic [XLEN-1:0] res_data;
    logic            res_err;
    logic [XLEN-1:0] ula_result;
    logic            ula_err;

    // Pick the only valid requester, or the one not served last on a tie.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_in && req1_valid_in) begin
            grant = ~last_grant;
        end else if (req1_valid_in) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst so the handshake drops the instant reset rises.
    assign in_idle        = (state == ST_IDLE) && !rst;
    assign in_resp        = (state == ST_RESP);
    assign req0_ready_out = in_idle && req0_valid_in && !grant;
    assign req1_ready_out = in_idle && req1_valid_in && grant;
    assign xfer           = req0_ready_out || req1_ready_out;
    assign rsp_ready_g    = gid ? rsp1_ready_in : rsp0_ready_in;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, one execute cycle, hold RESP until consumed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (xfer) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready_g) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Register the accepted operation, then capture the ula result in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gid        <= 1'b0;
            last_grant <= 1'b1;
            op_data1   <= '0;
            op_data2   <= '0;
            op_opcode  <= '0;
            op_funct3  <= '0;
            op_funct7  <= '0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            if (xfer) begin
                gid        <= grant;
                last_grant <= grant;
                op_data1   <= grant ? req1_data1_in  : req0_data1_in;
                op_data2   <= grant ? req1_data2_in  : req0_data2_in;
                op_opcode  <= grant ? req1_opcode_in : req0_opcode_in;
                op_funct3  <= grant ? req1_funct3_in : req0_funct3_in;
                op_funct7  <= grant ? req1_funct7_in : req0_funct7_in;
            end
            if (state == ST_EXEC) begin
                res_data <= ula_result;
                res_err  <= ula_err;
            end
        end
    end

    ula #(
        .XLEN   (XLEN)
    ) u_ula (
        .data1  (op_data1),
        .data2  (op_data2),
        .opcode (op_opcode),
        .funct3 (op_funct3),
        .funct7 (op_funct7),
        .result (ula_result),
        .err    (ula_err)
    );

    assign rsp0_valid_out = in_resp && !gid;
    assign rsp1_valid_out = in_resp && gid;
    assign rsp0_data_out  = rsp0_valid_out ? res_data : '0;
    assign rsp1_data_out  = rsp1_valid_out ? res_data : '0;
    assign rsp0_err_out   = rsp0_valid_out && res_err;
    assign rsp1_err_out   = rsp1_valid_out && res_err;

endmodule

// File: tb/tb_ula_arb.sv
// tb/tb_ula_arb.sv - self-checking bench for the ula arbiter
module tb_ula_arb;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_d1, req0_d2, req1_d1, req1_d2;
    logic [6:0]  req0_opc, req0_f7, req1_opc, req1_f7;
    logic [2:0]  req0_f3, req1_f3;
    logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;

    int vectors = 0;
    int miscompares = 0;
    logic last_grant;

    typedef struct {
        logic        port;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    ula_arb #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_in(req0_valid), .req0_ready_out(req0_ready),
        .req0_data1_in(req0_d1), .req0_data2_in(req0_d2),
        .req0_opcode_in(req0_opc), .req0_funct3_in(req0_f3), .req0_funct7_in(req0_f7),
        .req1_valid_in(req1_valid), .req1_ready_out(req1_ready),
        .req1_data1_in(req1_d1), .req1_data2_in(req1_d2),
        .req1_opcode_in(req1_opc), .req1_funct3_in(req1_f3), .req1_funct7_in(req1_f7),
        .rsp0_valid_out(rsp0_valid), .rsp0_ready_in(rsp0_ready),
        .rsp0_data_out(rsp0_data), .rsp0_err_out(rsp0_err),
        .rsp1_valid_out(rsp1_valid), .rsp1_ready_in(rsp1_ready),
        .rsp1_data_out(rsp1_data), .rsp1_err_out(rsp1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU written from the instruction semantics.
    function automatic logic [32:0] ref_ula(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        logic        alt;
        logic [31:0] r;
        if (opc != 7'b0110011 && opc != 7'b0010011) return {1'b1, 32'h0};
        s   = b[4:0];
        alt = (f7 == 7'b0100000);
        case (f3)
            3'd0:    r = (alt && opc == 7'b0110011) ? a + (~b + 32'd1) : a + b;
            3'd1:    r = a << s;
            3'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    r = (a < b) ? 32'd1 : 32'd0;
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? ((a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'h0)) : (a >> s);
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return {1'b0, r};
    endfunction

    function automatic logic pred_grant(input logic v0, input logic v1);
        if (v0 && v1) return ~last_grant;
        return v1;
    endfunction

    task automatic set_port(input logic p, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] d1, input logic [31:0] d2);
        if (p) begin
            req1_opc = opc; req1_f3 = f3; req1_f7 = f7; req1_d1 = d1; req1_d2 = d2;
        end else begin
            req0_opc = opc; req0_f3 = f3; req0_f7 = f7; req0_d1 = d1; req0_d2 = d2;
        end
    endtask

    // One full operation; entered and left just after a falling edge in IDLE.
    task automatic run_txn(input logic v0, input logic v1, input logic a0, input logic a1,
                           input int hold, input bit noise, input logic [31:0] exp_d,
                           input logic exp_e, input string tag);
        logic g;
        g = pred_grant(v0, v1);
        req0_valid = v0;
        req1_valid = v1;
        #1;
        chk({tag, ":ready0"}, req0_ready, (g == 1'b0));
        chk({tag, ":ready1"}, req1_ready, (g == 1'b1));
        @(posedge clk);
        last_grant = g;
        #1;
        req0_valid = a0;
        req1_valid = a1;
        @(negedge clk);
        chk({tag, ":exec_valid"}, {rsp1_valid, rsp0_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ":resp_valid"}, {rsp1_valid, rsp0_valid}, g ? 32'd2 : 32'd1);
        chk({tag, ":data"}, g ? rsp1_data : rsp0_data, exp_d);
        chk({tag, ":err"}, g ? rsp1_err : rsp0_err, exp_e);
        chk({tag, ":other_data"}, g ? rsp0_data : rsp1_data, 32'd0);
        chk({tag, ":resp_ready"}, {req1_ready, req0_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                req0_valid = 1'($urandom_range(0, 1));
                req1_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk({tag, ":hold_data"}, g ? rsp1_data : rsp0_data, exp_d);
            chk({tag, ":hold_valid"}, g ? rsp1_valid : rsp0_valid, 32'd1);
            chk({tag, ":hold_ready"}, {req1_ready, req0_ready}, 32'd0);
        end
        if (g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        #1;
        chk({tag, ":accept_ready"}, {req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk({tag, ":idle_valid"}, {rsp1_valid, rsp0_valid}, 32'd0);
        req0_valid = a0;
        req1_valid = a1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        last_grant = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[9];

    initial begin
        logic        v0, v1, g;
        logic [32:0] e;
        int          r;

        vecs[0] = '{1'b0, 32'h55555555, 32'hAAAAAAAA, 7'b0110011, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0};
        vecs[1] = '{1'b1, 32'h03800155, 32'h00055400, 7'b0110011, 3'd0, 7'h20, 32'h037AAD55, 1'b0};
        vecs[2] = '{1'b1, 32'h12345678, 32'h00000001, 7'b0000011, 3'd0, 7'h00, 32'h00000000, 1'b1};
        vecs[3] = '{1'b0, 32'h00000005, 32'h00000003, 7'b0010011, 3'd0, 7'h20, 32'h00000008, 1'b0};
        vecs[4] = '{1'b0, 32'h80000000, 32'h00000004, 7'b0110011, 3'd5, 7'h20, 32'hF8000000, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 7'b0110011, 3'd2, 7'h00, 32'h00000001, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 7'b0110011, 3'd3, 7'h00, 32'h00000000, 1'b0};
        vecs[7] = '{1'b0, 32'hF0F00000, 32'h0000F0F0, 7'b0110011, 3'd6, 7'h00, 32'hF0F0F0F0, 1'b0};
        vecs[8] = '{1'b1, 32'h80000010, 32'h00000004, 7'b0010011, 3'd5, 7'h20, 32'hF8000001, 1'b0};

        rst = 1'b1;
        last_grant = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        set_port(1'b0, 7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0);
        set_port(1'b1, 7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("reset:ready", {req1_ready, req0_ready}, 32'd0);
        chk("reset:valid", {rsp1_valid, rsp0_valid}, 32'd0);
        chk("reset:data0", rsp0_data, 32'd0);
        chk("reset:data1", rsp1_data, 32'd0);
        chk("reset:err", {rsp1_err, rsp0_err}, 32'd0);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            set_port(vecs[i].port, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].d1, vecs[i].d2);
            run_txn(!vecs[i].port, vecs[i].port, 1'b0, 1'b0, 1, 1'b0,
                    vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Tie after reset: port 0 first, then strict alternation.
        pulse_reset();
        set_port(1'b0, 7'b0110011, 3'd1, 7'h00, 32'h03800155, 32'h00000004);
        set_port(1'b1, 7'b0110011, 3'd5, 7'h00, 32'h03800155, 32'h00000004);
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h38001550, 1'b0, "rr0");
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h00380015, 1'b0, "rr1");
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 32'h38001550, 1'b0, "rr2");
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00380015, 1'b0, "rr3");

        // Back-pressure with port 1 waiting the whole time.
        set_port(1'b0, 7'b0110011, 3'd4, 7'h00, 32'h55555555, 32'hAAAAAAAA);
        set_port(1'b1, 7'b0010011, 3'd0, 7'h00, 32'h00000001, 32'h00000002);
        run_txn(1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0, 32'hFFFFFFFF, 1'b0, "bp");
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00000003, 1'b0, "bp_next");

        // Reset during EXEC discards the operation.
        set_port(1'b0, 7'b0110011, 3'd7, 7'h00, 32'hFF00FF00, 32'h0FF00FF0);
        req0_valid = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        last_grant = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_exec:ready", {req1_ready, req0_ready}, 32'd0);
        chk("rst_exec:valid", {rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_exec:data", rsp0_data | rsp1_data, 32'd0);
        chk("rst_exec:err", {rsp1_err, rsp0_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_exec:no_rsp", {rsp1_valid, rsp0_valid}, 32'd0);
        end
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0F000F00, 1'b0, "rst_exec:next");

        // Randomised operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++) begin
                logic [6:0] opc;
                r = $urandom_range(0, 9);
                if (r < 5) opc = 7'b0110011;
                else if (r < 9) opc = 7'b0010011;
                else opc = 7'($urandom);
                set_port(1'(p), opc, 3'($urandom_range(0, 7)),
                         ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, $urandom, $urandom);
            end
            r  = $urandom_range(1, 3);
            v0 = r[0];
            v1 = r[1];
            g  = pred_grant(v0, v1);
            e  = g ? ref_ula(req1_opc, req1_f3, req1_f7, req1_d1, req1_d2)
                   : ref_ula(req0_opc, req0_f3, req0_f7, req0_d1, req0_d2);
            run_txn(v0, v1, 1'b0, 1'b0, $urandom_range(0, 3), 1'b1, e[31:0], e[32],
                    $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
